// File: rtl/el2_pkg.sv
// rtl/el2_pkg.sv - AXI response codes, slave FSM state types and byte-merge helper.
package el2_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_BRESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RRESP
  } rd_state_e;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_data,
                                              input logic [63:0] new_data,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_data;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/el2_lsu_axi_slv_mem.sv
// rtl/el2_lsu_axi_slv_mem.sv - byte-enabled 64-bit word array, 1R1W, sync write, async read.
module el2_lsu_axi_slv_mem
  import el2_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  // Contents deliberately survive reset.
  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merge_bytes(mem[waddr], wdata, wstrb);
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/el2_lsu_axi_slv.sv
// rtl/el2_lsu_axi_slv.sv - single-beat AXI4 responder for LSU traffic over a 64-bit memory window.
// Define RV_AXI_SLV_DECERR_EN to answer out-of-window addresses with DECERR instead of wrapping.
module el2_lsu_axi_slv
  import el2_pkg::*;
#(
  parameter int          TAG   = 4,
  parameter int          DEPTH = 256,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           axi_awvalid,
  output logic           axi_awready,
  input  logic [TAG-1:0] axi_awid,
  input  logic [31:0]    axi_awaddr,
  input  logic [7:0]     axi_awlen,
  input  logic [2:0]     axi_awsize,
  input  logic           axi_wvalid,
  output logic           axi_wready,
  input  logic [63:0]    axi_wdata,
  input  logic [7:0]     axi_wstrb,
  input  logic           axi_wlast,
  output logic           axi_bvalid,
  input  logic           axi_bready,
  output logic [1:0]     axi_bresp,
  output logic [TAG-1:0] axi_bid,
  input  logic           axi_arvalid,
  output logic           axi_arready,
  input  logic [TAG-1:0] axi_arid,
  input  logic [31:0]    axi_araddr,
  input  logic [7:0]     axi_arlen,
  input  logic [2:0]     axi_arsize,
  output logic           axi_rvalid,
  input  logic           axi_rready,
  output logic [TAG-1:0] axi_rid,
  output logic [63:0]    axi_rdata,
  output logic [1:0]     axi_rresp,
  output logic           axi_rlast
);

  localparam int IW = $clog2(DEPTH);

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic [TAG-1:0] aw_id_q;
  logic [IW-1:0]  aw_idx_q;
  logic           aw_len_bad_q, aw_dec_q;
  logic [63:0]    w_data_q;
  logic [7:0]     w_strb_q;
  logic           w_last_q;

  logic           aw_hs, w_hs, ar_hs;
  logic           aw_dec, ar_dec;
  logic [IW-1:0]  ar_idx;
  logic [1:0]     commit_resp;
  logic           mem_we;
  logic [63:0]    mem_rdata, rd_word;
  logic           unused_size;

  assign unused_size = ^{axi_awsize, axi_arsize};

  function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
    return IW'((addr - BASE) >> 3);
  endfunction

`ifdef RV_AXI_SLV_DECERR_EN
  // Addresses below BASE wrap to huge offsets, so one unsigned compare covers both ends.
  function automatic logic out_of_window(input logic [31:0] addr);
    return {1'b0, addr - BASE} >= (33'(DEPTH) * 33'd8);
  endfunction
  assign aw_dec = out_of_window(axi_awaddr);
  assign ar_dec = out_of_window(axi_araddr);
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
`endif

  always_comb begin
    wr_next     = wr_state;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        if (axi_awvalid && axi_wvalid) wr_next = WR_COMMIT;
        else if (axi_awvalid)          wr_next = WR_HAVE_AW;
        else if (axi_wvalid)           wr_next = WR_HAVE_W;
      end
      WR_HAVE_AW: begin
        axi_wready = 1'b1;
        if (axi_wvalid) wr_next = WR_COMMIT;
      end
      WR_HAVE_W: begin
        axi_awready = 1'b1;
        if (axi_awvalid) wr_next = WR_COMMIT;
      end
      WR_COMMIT: wr_next = WR_BRESP;
      WR_BRESP: begin
        axi_bvalid = 1'b1;
        if (axi_bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;

  assign commit_resp = aw_dec_q                   ? AXI_RESP_DECERR :
                       (aw_len_bad_q || !w_last_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign mem_we = (wr_state == WR_COMMIT) && (commit_resp == AXI_RESP_OKAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state     <= WR_IDLE;
      aw_id_q      <= '0;
      aw_idx_q     <= '0;
      aw_len_bad_q <= 1'b0;
      aw_dec_q     <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      w_last_q     <= 1'b0;
      axi_bresp    <= AXI_RESP_OKAY;
      axi_bid      <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_id_q      <= axi_awid;
        aw_idx_q     <= word_idx(axi_awaddr);
        aw_len_bad_q <= (axi_awlen != 8'd0);
        aw_dec_q     <= aw_dec;
      end
      if (w_hs) begin
        w_data_q <= axi_wdata;
        w_strb_q <= axi_wstrb;
        w_last_q <= axi_wlast;
      end
      if (wr_state == WR_COMMIT) begin
        axi_bresp <= commit_resp;
        axi_bid   <= aw_id_q;
      end
    end
  end

  always_comb begin
    rd_next     = rd_state;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        axi_arready = 1'b1;
        if (axi_arvalid) rd_next = RD_RRESP;
      end
      RD_RRESP: begin
        axi_rvalid = 1'b1;
        if (axi_rready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign ar_hs     = axi_arvalid && axi_arready;
  assign ar_idx    = word_idx(axi_araddr);
  assign axi_rlast = 1'b1;

  // A commit landing on the same edge as the read capture is forwarded so the read sees it.
  assign rd_word = (mem_we && (aw_idx_q == ar_idx)) ? merge_bytes(mem_rdata, w_data_q, w_strb_q)
                                                    : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      axi_rid   <= '0;
      axi_rdata <= '0;
      axi_rresp <= AXI_RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        axi_rid <= axi_arid;
        if (ar_dec) begin
          axi_rresp <= AXI_RESP_DECERR;
          axi_rdata <= '0;
        end else if (axi_arlen != 8'd0) begin
          axi_rresp <= AXI_RESP_SLVERR;
          axi_rdata <= '0;
        end else begin
          axi_rresp <= AXI_RESP_OKAY;
          axi_rdata <= rd_word;
        end
      end
    end
  end

  el2_lsu_axi_slv_mem #(
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (aw_idx_q),
    .wdata (w_data_q),
    .wstrb (w_strb_q),
    .raddr (ar_idx),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_el2_lsu_axi_slv.sv
// tb/tb_el2_lsu_axi_slv.sv - directed self-checking bench for el2_lsu_axi_slv.
module tb_el2_lsu_axi_slv;

  localparam int          TAG   = 4;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           axi_awvalid = 1'b0, axi_awready;
  logic [TAG-1:0] axi_awid = '0;
  logic [31:0]    axi_awaddr = '0;
  logic [7:0]     axi_awlen = '0;
  logic [2:0]     axi_awsize = 3'd3;
  logic           axi_wvalid = 1'b0, axi_wready;
  logic [63:0]    axi_wdata = '0;
  logic [7:0]     axi_wstrb = '0;
  logic           axi_wlast = 1'b0;
  logic           axi_bvalid, axi_bready = 1'b0;
  logic [1:0]     axi_bresp;
  logic [TAG-1:0] axi_bid;
  logic           axi_arvalid = 1'b0, axi_arready;
  logic [TAG-1:0] axi_arid = '0;
  logic [31:0]    axi_araddr = '0;
  logic [7:0]     axi_arlen = '0;
  logic [2:0]     axi_arsize = 3'd3;
  logic           axi_rvalid, axi_rready = 1'b0;
  logic [TAG-1:0] axi_rid;
  logic [63:0]    axi_rdata;
  logic [1:0]     axi_rresp;
  logic           axi_rlast;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  el2_lsu_axi_slv #(.TAG(TAG), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic write_word(input string tag, input logic [TAG-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [63:0] data, input logic [7:0] strb,
                            input logic last, input logic [1:0] exp_resp);
    axi_awvalid = 1'b1; axi_awid = id; axi_awaddr = addr; axi_awlen = len;
    axi_wvalid = 1'b1; axi_wdata = data; axi_wstrb = strb; axi_wlast = last;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    tick();
    check({tag, "_bvalid"}, 64'(axi_bvalid), 64'd1);
    check({tag, "_bid"}, 64'(axi_bid), 64'(id));
    check({tag, "_bresp"}, 64'(axi_bresp), 64'(exp_resp));
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [TAG-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [63:0] exp_data,
                           input logic [1:0] exp_resp);
    axi_arvalid = 1'b1; axi_arid = id; axi_araddr = addr; axi_arlen = len;
    tick();
    axi_arvalid = 1'b0;
    check({tag, "_rvalid"}, 64'(axi_rvalid), 64'd1);
    check({tag, "_rid"}, 64'(axi_rid), 64'(id));
    check({tag, "_rdata"}, axi_rdata, exp_data);
    check({tag, "_rresp"}, 64'(axi_rresp), 64'(exp_resp));
    check({tag, "_rlast"}, 64'(axi_rlast), 64'd1);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    check("rst_awready", 64'(axi_awready), 64'd1);
    check("rst_wready", 64'(axi_wready), 64'd1);
    check("rst_arready", 64'(axi_arready), 64'd1);
    check("rst_bvalid", 64'(axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(axi_rvalid), 64'd0);
    check("rst_bresp", 64'(axi_bresp), 64'd0);
    check("rst_rresp", 64'(axi_rresp), 64'd0);
    check("rst_bid", 64'(axi_bid), 64'd0);
    check("rst_rid", 64'(axi_rid), 64'd0);
    check("rst_rdata", axi_rdata, 64'd0);
    rst = 1'b0;
    tick();

    // clear words used below
    write_word("init0", 4'd0, BASE + 32'h00, 8'd0, 64'd0, 8'hFF, 1'b1, 2'b00);
    write_word("init2", 4'd0, BASE + 32'h10, 8'd0, 64'd0, 8'hFF, 1'b1, 2'b00);

    // AW+W same cycle: bvalid two cycles after handshake
    axi_awvalid = 1'b1; axi_awid = 4'd3; axi_awaddr = BASE + 32'h8; axi_awlen = 8'd0;
    axi_wvalid = 1'b1; axi_wdata = 64'h1122334455667788; axi_wstrb = 8'hFF; axi_wlast = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("aww_commit_bvalid", 64'(axi_bvalid), 64'd0);
    check("aww_commit_awready", 64'(axi_awready), 64'd0);
    tick();
    check("aww_bvalid", 64'(axi_bvalid), 64'd1);
    check("aww_bid", 64'(axi_bid), 64'd3);
    check("aww_bresp", 64'(axi_bresp), 64'd0);
    tick();
    check("aww_bhold_bvalid", 64'(axi_bvalid), 64'd1);
    check("aww_bhold_bid", 64'(axi_bid), 64'd3);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    check("aww_idle_bvalid", 64'(axi_bvalid), 64'd0);
    check("aww_idle_awready", 64'(axi_awready), 64'd1);
    read_word("rd8", 4'd1, BASE + 32'h8, 8'd0, 64'h1122334455667788, 2'b00);

    // W three cycles before AW, lower-half strobe
    axi_wvalid = 1'b1; axi_wdata = 64'hDEADBEEF55667788; axi_wstrb = 8'h0F; axi_wlast = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    check("havew_wready", 64'(axi_wready), 64'd0);
    check("havew_awready", 64'(axi_awready), 64'd1);
    tick(); tick();
    check("havew_bvalid", 64'(axi_bvalid), 64'd0);
    axi_awvalid = 1'b1; axi_awid = 4'd7; axi_awaddr = BASE + 32'h10; axi_awlen = 8'd0;
    tick();
    axi_awvalid = 1'b0;
    tick();
    check("wfirst_bvalid", 64'(axi_bvalid), 64'd1);
    check("wfirst_bid", 64'(axi_bid), 64'd7);
    check("wfirst_bresp", 64'(axi_bresp), 64'd0);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    read_word("rd10", 4'd2, BASE + 32'h10, 8'd0, 64'h0000000055667788, 2'b00);

    // read held under backpressure
    axi_arvalid = 1'b1; axi_arid = 4'd5; axi_araddr = BASE + 32'h8; axi_arlen = 8'd0;
    tick();
    axi_arid = 4'd9; axi_araddr = BASE + 32'h10;
    for (int i = 0; i < 4; i++) begin
      check("bp_rvalid", 64'(axi_rvalid), 64'd1);
      check("bp_rid", 64'(axi_rid), 64'd5);
      check("bp_rdata", axi_rdata, 64'h1122334455667788);
      check("bp_arready", 64'(axi_arready), 64'd0);
      tick();
    end
    axi_arvalid = 1'b0;
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check("bp_done_rvalid", 64'(axi_rvalid), 64'd0);
    check("bp_done_arready", 64'(axi_arready), 64'd1);

    // burst requests rejected
    read_word("arlen1", 4'd4, BASE + 32'h8, 8'd1, 64'd0, 2'b10);
    write_word("awlen3", 4'd6, BASE + 32'h8, 8'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 2'b10);
    write_word("nowlast", 4'd8, BASE + 32'h8, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 2'b10);
    read_word("rd8_unchanged", 4'd1, BASE + 32'h8, 8'd0, 64'h1122334455667788, 2'b00);

    // commit and read of the same word on the same edge
    write_word("pre18", 4'd0, BASE + 32'h18, 8'd0, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 2'b00);
    axi_awvalid = 1'b1; axi_awid = 4'd10; axi_awaddr = BASE + 32'h18; axi_awlen = 8'd0;
    axi_wvalid = 1'b1; axi_wdata = 64'hFFFFFFFFFFFFFFFF; axi_wstrb = 8'hF0; axi_wlast = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    axi_arvalid = 1'b1; axi_arid = 4'd11; axi_araddr = BASE + 32'h18; axi_arlen = 8'd0;
    tick();
    axi_arvalid = 1'b0;
    check("byp_rvalid", 64'(axi_rvalid), 64'd1);
    check("byp_rdata", axi_rdata, 64'hFFFFFFFF89ABCDEF);
    check("byp_bvalid", 64'(axi_bvalid), 64'd1);
    check("byp_bid", 64'(axi_bid), 64'd10);
    axi_bready = 1'b1; axi_rready = 1'b1;
    tick();
    axi_bready = 1'b0; axi_rready = 1'b0;

    // first address past the window
`ifdef RV_AXI_SLV_DECERR_EN
    write_word("oow_wr", 4'd12, BASE + 32'h800, 8'd0, 64'hCAFEF00D12345678, 8'hFF, 1'b1, 2'b11);
    read_word("oow_rd", 4'd13, BASE + 32'h800, 8'd0, 64'd0, 2'b11);
    read_word("oow_w0", 4'd14, BASE + 32'h0, 8'd0, 64'd0, 2'b00);
`else
    write_word("oow_wr", 4'd12, BASE + 32'h800, 8'd0, 64'hCAFEF00D12345678, 8'hFF, 1'b1, 2'b00);
    read_word("oow_rd", 4'd13, BASE + 32'h800, 8'd0, 64'hCAFEF00D12345678, 2'b00);
    read_word("oow_w0", 4'd14, BASE + 32'h0, 8'd0, 64'hCAFEF00D12345678, 2'b00);
`endif

    // reset while holding an AW
    axi_awvalid = 1'b1; axi_awid = 4'd2; axi_awaddr = BASE + 32'h8; axi_awlen = 8'd0;
    tick();
    axi_awvalid = 1'b0;
    check("haveaw_awready", 64'(axi_awready), 64'd0);
    check("haveaw_wready", 64'(axi_wready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstaw_awready", 64'(axi_awready), 64'd1);
    check("rstaw_wready", 64'(axi_wready), 64'd1);
    check("rstaw_bvalid", 64'(axi_bvalid), 64'd0);
    tick();
    check("rstaw_bvalid2", 64'(axi_bvalid), 64'd0);
    read_word("rstaw_rd8", 4'd3, BASE + 32'h8, 8'd0, 64'h1122334455667788, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/el2_lsu_axi_slv.md
EL2_LSU_AXI_SLV -- requirements
Module: el2_lsu_axi_slv

Interface
REQ-001 SHALL have parameter TAG, default 4, meaning AXI ID width.
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of 64-bit memory words (power of 2).
REQ-003 SHALL have parameter BASE, default 32'h0000_0000, meaning base byte address of the window.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have write-address ports axi_awvalid in 1, axi_awready out 1, axi_awid in TAG, axi_awaddr in 32, axi_awlen in 8, axi_awsize in 3.
REQ-007 SHALL have write-data ports axi_wvalid in 1, axi_wready out 1, axi_wdata in 64, axi_wstrb in 8, axi_wlast in 1.
REQ-008 SHALL have write-response ports axi_bvalid out 1, axi_bready in 1, axi_bresp out 2, axi_bid out TAG.
REQ-009 SHALL have read-address ports axi_arvalid in 1, axi_arready out 1, axi_arid in TAG, axi_araddr in 32, axi_arlen in 8, axi_arsize in 3.
REQ-010 SHALL have read-data ports axi_rvalid out 1, axi_rready in 1, axi_rid out TAG, axi_rdata out 64, axi_rresp out 2, axi_rlast out 1 (always 1).

Function
REQ-011 SHALL act as the AXI4 responder for single-beat LSU traffic; word index = (addr-BASE)[3+log2(DEPTH)-1:3].
REQ-012 Write FSM SHALL have states IDLE, HAVE_AW, HAVE_W, COMMIT, BRESP.
REQ-013 IDLE: awready=wready=1; AW only -> HAVE_AW; W only -> HAVE_W; both same cycle -> COMMIT.
REQ-014 HAVE_AW: wready=1, awready=0; HAVE_W: awready=1, wready=0; completing handshake -> COMMIT.
REQ-015 COMMIT: write bytes with wstrb set, unset bytes unchanged; -> BRESP next cycle.
REQ-016 BRESP: bvalid=1, bid=captured awid, held stable until bready; on handshake -> IDLE.
REQ-017 awlen!=0 or wlast=0 SHALL give bresp=SLVERR and no array write.
REQ-018 Read FSM SHALL have states IDLE, RRESP; arready=1 only in IDLE.
REQ-019 AR handshake in cycle N SHALL give rvalid in cycle N+1, data captured at N+1; rid/rdata/rresp stable until rready.
REQ-020 arlen!=0 SHALL give rresp=SLVERR, rdata=0.
REQ-021 Same-cycle COMMIT and AR to same word: read returns post-write data (write-through bypass).
REQ-022 Read and write channels SHALL be independent; no ordering between bid and rid streams.
REQ-023 axi_awsize/axi_arsize SHALL be ignored for data; wstrb alone selects bytes.

Reset
REQ-024 On rst: both FSMs IDLE; bvalid=rvalid=0; bresp=rresp=0; bid=rid=0; rdata=0.
REQ-025 Reset mid-transaction SHALL drop pending AW/W/B/R with no array write; array contents not reset.

Configuration
REQ-026 With RV_AXI_SLV_DECERR_EN defined: address outside [BASE, BASE+8*DEPTH) gives DECERR (2'b11), write dropped, rdata=0.
REQ-027 Without RV_AXI_SLV_DECERR_EN: address index wraps modulo DEPTH, response OKAY.

Structure
REQ-028 AXI response codes (OKAY, EXOKAY, SLVERR, DECERR) and FSM state enums SHALL live in el2_pkg.
REQ-029 Byte-enabled 64-bit array SHALL be sub-module el2_lsu_axi_slv_mem (1R1W, sync write, async read).

Verification
REQ-030 AW+W same cycle, addr BASE+8, wdata 64'h1122334455667788, wstrb FF, id 3 -> bvalid 2 cycles later, bid 3, bresp 0.
REQ-031 W three cycles before AW, wstrb 8'h0F on word holding 0 -> later read returns 64'h0000000055667788.
REQ-032 AR id 5 with rready=0 for 4 cycles -> rvalid/rid/rdata stable; arready=0 until handshake.
REQ-033 arlen=1 -> rresp 2'b10, rdata 0; awlen=3 -> bresp 2'b10, memory unchanged.
REQ-034 Address BASE+8*DEPTH: with macro -> resp 2'b11; without -> OKAY, accesses word 0.
REQ-035 rst asserted in HAVE_AW -> next cycle awready=wready=1, bvalid=0, no write observed.
